// File: rtl/cpu_defs.sv
// Shared definitions for the accumulator CPU control path: opcodes, register select codes,
// ALU operation codes and the sequencer state encoding.
package cpu_defs;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_JUMP = 4'h7;
  localparam logic [3:0] OP_JMPZ = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Register codes shared by the write-enable decoder and the bus source mux
  localparam logic [2:0] SEL_AC  = 3'd0;
  localparam logic [2:0] SEL_AR  = 3'd1;
  localparam logic [2:0] SEL_DR  = 3'd2;
  localparam logic [2:0] SEL_IR  = 3'd3;
  localparam logic [2:0] SEL_PC  = 3'd4;
  localparam logic [2:0] SEL_R   = 3'd5;
  localparam logic [2:0] SEL_TR  = 3'd6;
  localparam logic [2:0] SEL_MEM = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;

  typedef enum logic [4:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_DEC,
    S_LDAC_E0,
    S_LDAC_E1,
    S_LDAC_E2,
    S_STAC_E0,
    S_STAC_E1,
    S_STAC_E2,
    S_MVAC_E0,
    S_MOVR_E0,
    S_ADD_E0,
    S_SUB_E0,
    S_JUMP_E0,
    S_HALT
  } state_t;

endpackage

// File: rtl/control_opdecode.sv
// Opcode decoder: maps the instruction opcode to the first execute state.
// JMPZ reports the jump state and flags itself so the sequencer can apply the Z condition.
module control_opdecode
  import cpu_defs::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output state_t           first_state,
  output logic             is_jmpz,
  output logic             illegal
);

  always_comb begin
    first_state = S_F0;
    is_jmpz     = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPC_W'(OP_NOP):  first_state = S_F0;
      OPC_W'(OP_LDAC): first_state = S_LDAC_E0;
      OPC_W'(OP_STAC): first_state = S_STAC_E0;
      OPC_W'(OP_MVAC): first_state = S_MVAC_E0;
      OPC_W'(OP_MOVR): first_state = S_MOVR_E0;
      OPC_W'(OP_ADD):  first_state = S_ADD_E0;
      OPC_W'(OP_SUB):  first_state = S_SUB_E0;
      OPC_W'(OP_JUMP): first_state = S_JUMP_E0;
      OPC_W'(OP_JMPZ): begin
        first_state = S_JUMP_E0;
        is_jmpz     = 1'b1;
      end
      OPC_W'(OP_HALT): first_state = S_HALT;
      default: begin
        first_state = S_F0;
        illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Drives register write select, bus source, ALU op, PC increment and memory read handshake.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int OPC_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             z_flag,
  input  logic             mem_ack,
  output logic [2:0]       wr_sel,
  output logic             wr_valid,
  output logic [2:0]       bus_sel,
  output logic [1:0]       alu_op,
  output logic             pc_inc,
  output logic             mem_rd,
  output logic             halted,
  output logic             mem_err,
  output logic             illegal
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_err_reg, mem_err_next;

  state_t     dec_state;
  logic       dec_jmpz;
  logic       dec_illegal;

  control_opdecode #(
    .OPC_W(OPC_W)
  ) u_opdecode (
    .opcode     (opcode),
    .first_state(dec_state),
    .is_jmpz    (dec_jmpz),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    case (state_reg)
      S_IDLE: if (run) state_next = S_F0;
      S_F0: begin
        state_next    = S_F1;
        wait_cnt_next = '0;
      end
      S_F2:      state_next = S_DEC;
      S_DEC: begin
        if (dec_jmpz) state_next = z_flag ? S_JUMP_E0 : S_F0;
        else          state_next = dec_state;
      end
      S_LDAC_E0: begin
        state_next    = S_LDAC_E1;
        wait_cnt_next = '0;
      end
      S_STAC_E0: state_next = S_STAC_E1;
      S_STAC_E1: begin
        state_next    = S_STAC_E2;
        wait_cnt_next = '0;
      end
      S_F1, S_LDAC_E1, S_STAC_E2: begin
        // Memory wait: leave on ack, otherwise count toward the timeout fault
        if (mem_ack) begin
          case (state_reg)
            S_F1:      state_next = S_F2;
            S_LDAC_E1: state_next = S_LDAC_E2;
            default:   state_next = S_F0;
          endcase
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next   = S_HALT;
          mem_err_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_F0;
    endcase
  end

  always_comb begin
    wr_sel   = SEL_AC;
    wr_valid = 1'b0;
    bus_sel  = SEL_AC;
    alu_op   = ALU_PASS;
    pc_inc   = 1'b0;
    mem_rd   = 1'b0;
    case (state_reg)
      S_F0: begin
        bus_sel = SEL_PC;  wr_sel = SEL_AR;  wr_valid = 1'b1;
      end
      S_F1: begin
        mem_rd  = 1'b1;
        bus_sel = SEL_MEM;
        if (mem_ack) begin
          wr_sel = SEL_DR;  wr_valid = 1'b1;  pc_inc = 1'b1;
        end
      end
      S_F2: begin
        bus_sel = SEL_DR;  wr_sel = SEL_IR;  wr_valid = 1'b1;
      end
      S_LDAC_E0, S_STAC_E0: begin
        bus_sel = SEL_R;  wr_sel = SEL_AR;  wr_valid = 1'b1;
      end
      S_LDAC_E1: begin
        mem_rd  = 1'b1;
        bus_sel = SEL_MEM;
        if (mem_ack) begin
          wr_sel = SEL_DR;  wr_valid = 1'b1;
        end
      end
      S_LDAC_E2: begin
        bus_sel = SEL_DR;  wr_sel = SEL_AC;  wr_valid = 1'b1;
      end
      S_STAC_E1: begin
        bus_sel = SEL_AC;  wr_sel = SEL_DR;  wr_valid = 1'b1;
      end
      S_STAC_E2: begin
        wr_sel = SEL_MEM;  wr_valid = 1'b1;
      end
      S_MVAC_E0: begin
        bus_sel = SEL_AC;  wr_sel = SEL_R;  wr_valid = 1'b1;
      end
      S_MOVR_E0: begin
        bus_sel = SEL_R;  wr_sel = SEL_AC;  wr_valid = 1'b1;
      end
      S_ADD_E0: begin
        bus_sel = SEL_R;  alu_op = ALU_ADD;  wr_sel = SEL_AC;  wr_valid = 1'b1;
      end
      S_SUB_E0: begin
        bus_sel = SEL_R;  alu_op = ALU_SUB;  wr_sel = SEL_AC;  wr_valid = 1'b1;
      end
      S_JUMP_E0: begin
        bus_sel = SEL_R;  wr_sel = SEL_PC;  wr_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted  = (state_reg == S_HALT);
  assign mem_err = mem_err_reg;
  assign illegal = (state_reg == S_DEC) && dec_illegal;

endmodule
